// File: rtl/hazard_scheduler.sv
// rtl/hazard_scheduler.sv - load-use stall, EX bubble and operand forwarding control for a 5-stage pipeline
// Tracks EX/MEM/WB producer records; stalls one cycle per load-use pair and counts stall cycles.
module hazard_scheduler #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              id_we_r,
  input  logic              id_ma,
  input  logic [REG_AW-1:0] id_destAddr,
  output logic              stall,
  output logic              pc_en,
  output logic              ex_bubble,
  output logic [1:0]        fwdA,
  output logic [1:0]        fwdB,
  output logic              mem_we_r,
  output logic              wb_we_r,
  output logic [REG_AW-1:0] wb_destAddr,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              r_ex_valid, r_ex_we_r, r_ex_ma, r_ex_uses_rt;
  logic [REG_AW-1:0] r_ex_dest, r_ex_rs, r_ex_rt;
  logic              r_mem_valid, r_mem_we_r, r_mem_ma;
  logic [REG_AW-1:0] r_mem_dest;
  logic              r_wb_valid, r_wb_we_r, r_wb_ma;
  logic [REG_AW-1:0] r_wb_dest;
  logic [CNT_W-1:0]  r_stall_count;

  logic w_hz, w_advance, w_mem_fwd_ok, w_wb_fwd_ok;

  // A load in EX cannot forward yet, so a dependent decode instruction must wait one cycle.
  assign w_hz = id_valid & r_ex_valid & r_ex_ma & r_ex_we_r & (r_ex_dest != '0) &
                ((r_ex_dest == id_rs) | (id_uses_rt & (r_ex_dest == id_rt)));
  assign w_advance = id_valid & ~w_hz;

  assign stall     = w_hz;
  assign pc_en     = ~w_hz;
  assign ex_bubble = ~w_advance;

  // A MEM-stage load has no ALU result to offer; only the WB stage can supply loaded data.
  assign w_mem_fwd_ok = r_mem_valid & r_mem_we_r & ~r_mem_ma & (r_mem_dest != '0);
  assign w_wb_fwd_ok  = r_wb_valid & r_wb_we_r & (r_wb_dest != '0);

  always_comb begin
    fwdA = 2'b00;
    fwdB = 2'b00;
    if (r_ex_valid) begin
      if (w_mem_fwd_ok && (r_mem_dest == r_ex_rs))
        fwdA = 2'b01;
      else if (w_wb_fwd_ok && (r_wb_dest == r_ex_rs))
        fwdA = 2'b10;
      if (r_ex_uses_rt) begin
        if (w_mem_fwd_ok && (r_mem_dest == r_ex_rt))
          fwdB = 2'b01;
        else if (w_wb_fwd_ok && (r_wb_dest == r_ex_rt))
          fwdB = 2'b10;
      end
    end
  end

  assign mem_we_r    = r_mem_valid & r_mem_we_r;
  assign wb_we_r     = r_wb_valid & r_wb_we_r;
  assign wb_destAddr = r_wb_dest;
  assign stall_count = r_stall_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid    <= 1'b0;
      r_ex_we_r     <= 1'b0;
      r_ex_ma       <= 1'b0;
      r_ex_uses_rt  <= 1'b0;
      r_ex_dest     <= '0;
      r_ex_rs       <= '0;
      r_ex_rt       <= '0;
      r_mem_valid   <= 1'b0;
      r_mem_we_r    <= 1'b0;
      r_mem_ma      <= 1'b0;
      r_mem_dest    <= '0;
      r_wb_valid    <= 1'b0;
      r_wb_we_r     <= 1'b0;
      r_wb_ma       <= 1'b0;
      r_wb_dest     <= '0;
      r_stall_count <= '0;
    end else begin
      r_wb_valid   <= r_mem_valid;
      r_wb_we_r    <= r_mem_we_r;
      r_wb_ma      <= r_mem_ma;
      r_wb_dest    <= r_mem_dest;
      r_mem_valid  <= r_ex_valid;
      r_mem_we_r   <= r_ex_we_r;
      r_mem_ma     <= r_ex_ma;
      r_mem_dest   <= r_ex_dest;
      r_ex_valid   <= w_advance;
      r_ex_we_r    <= id_we_r;
      r_ex_ma      <= id_ma;
      r_ex_uses_rt <= id_uses_rt;
      r_ex_dest    <= id_destAddr;
      r_ex_rs      <= id_rs;
      r_ex_rt      <= id_rt;
      if (w_hz && (r_stall_count != CNT_MAX))
        r_stall_count <= r_stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb/tb_hazard_scheduler.sv - directed self-checking bench for hazard_scheduler
// Narrow stall counter keeps the saturation walk short.
module tb_hazard_scheduler;

  localparam int AW   = 5;
  localparam int CW   = 10;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_uses_rt, id_we_r, id_ma;
  logic [AW-1:0] id_rs, id_rt, id_destAddr;
  logic          stall, pc_en, ex_bubble, mem_we_r, wb_we_r;
  logic [1:0]    fwdA, fwdB;
  logic [AW-1:0] wb_destAddr;
  logic [CW-1:0] stall_count;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  hazard_scheduler #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_we_r(id_we_r), .id_ma(id_ma), .id_destAddr(id_destAddr),
    .stall(stall), .pc_en(pc_en), .ex_bubble(ex_bubble), .fwdA(fwdA), .fwdB(fwdB),
    .mem_we_r(mem_we_r), .wb_we_r(wb_we_r), .wb_destAddr(wb_destAddr),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic urt, input logic we, input logic ma, input logic [AW-1:0] dst);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    id_we_r = we; id_ma = ma; id_destAddr = dst;
    #1;
  endtask

  task automatic drain(input int n);
    set_id(0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  // A load sitting in MEM while its consumer is in EX means the stall was missed.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("no_fwd_11", {31'd0, (fwdA == 2'b11) || (fwdB == 2'b11)}, 32'd0);
      check("no_load_in_mem_hazard",
            {31'd0, dut.r_mem_valid && dut.r_mem_ma && dut.r_mem_we_r && (dut.r_mem_dest != 0) &&
                    dut.r_ex_valid && ((dut.r_mem_dest == dut.r_ex_rs) ||
                    (dut.r_ex_uses_rt && (dut.r_mem_dest == dut.r_ex_rt)))}, 32'd0);
    end
  end

  initial begin
    // reset with random decode inputs
    rst = 1'b1;
    set_id(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
    tick();
    set_id(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
    tick();
    rst = 1'b0;
    set_id(1, 1, 2, 1, 1, 0, 1);
    check("rst_stall", stall, 0);
    check("rst_pc_en", pc_en, 1);
    check("rst_ex_bubble", ex_bubble, 0);
    check("rst_fwd", {fwdA, fwdB}, 0);
    check("rst_we", {mem_we_r, wb_we_r}, 0);
    check("rst_wb_dest", wb_destAddr, 0);
    check("rst_count", stall_count, 0);
    mon_en = 1'b1;
    tick();
    drain(3);

    // add $3,$1,$2 ; sub $4,$3,$5 ; and $10,$3,$11
    set_id(1, 1, 2, 1, 1, 0, 3);
    check("alu_add_nostall", stall, 0);
    tick();
    set_id(1, 3, 5, 1, 1, 0, 4);
    check("alu_sub_nostall", stall, 0);
    tick();
    set_id(1, 3, 11, 1, 1, 0, 10);
    check("alu_sub_fwdA_mem", fwdA, 2'b01);
    check("alu_sub_fwdB", fwdB, 2'b00);
    check("alu_mem_we", mem_we_r, 1);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    check("alu_and_fwdA_wb", fwdA, 2'b10);
    check("alu_wb_we", wb_we_r, 1);
    check("alu_wb_dest", wb_destAddr, 3);
    drain(3);

    // lw $8,0($1) ; add $9,$8,$2
    set_id(1, 1, 8, 0, 1, 1, 8);
    check("lu_lw_nostall", stall, 0);
    tick();
    set_id(1, 8, 2, 1, 1, 0, 9);
    check("lu_stall", stall, 1);
    check("lu_pc_en", pc_en, 0);
    check("lu_bubble", ex_bubble, 1);
    tick();
    check("lu_stall_once", stall, 0);
    check("lu_advance", ex_bubble, 0);
    check("lu_count", stall_count, 1);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    check("lu_fwdA_wb", fwdA, 2'b10);
    check("lu_fwdB", fwdB, 2'b00);
    drain(3);

    // lw $6,0($2) ; sw $6,4($2)
    set_id(1, 2, 6, 0, 1, 1, 6);
    tick();
    set_id(1, 2, 6, 1, 0, 0, 0);
    check("st_stall", stall, 1);
    tick();
    check("st_stall_once", stall, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    check("st_fwdB_wb", fwdB, 2'b10);
    check("st_fwdA", fwdA, 2'b00);
    check("st_count", stall_count, 2);
    drain(3);

    // add $0 ; lw $0 ; reader of $0
    set_id(1, 1, 2, 1, 1, 0, 0);
    tick();
    set_id(1, 3, 0, 0, 1, 1, 0);
    tick();
    set_id(1, 0, 0, 1, 1, 0, 13);
    check("r0_nostall", stall, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    check("r0_fwd", {fwdA, fwdB}, 0);
    drain(3);

    // add $7 twice ; reader rs=$7, rt=$7 but uses_rt=0
    set_id(1, 1, 2, 1, 1, 0, 7);
    tick();
    set_id(1, 3, 4, 1, 1, 0, 7);
    tick();
    set_id(1, 7, 7, 0, 1, 0, 14);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    check("prio_fwdA_mem", fwdA, 2'b01);
    check("prio_fwdB_gated", fwdB, 2'b00);
    drain(3);

    // store as producer never forwards
    set_id(1, 1, 5, 1, 0, 0, 5);
    tick();
    set_id(1, 5, 5, 1, 1, 0, 15);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    check("sw_no_fwd", {fwdA, fwdB}, 0);
    check("sw_mem_we", mem_we_r, 0);
    drain(3);

    // invalid decode behind a load: no stall, bubble, count unchanged
    set_id(1, 1, 8, 0, 1, 1, 8);
    tick();
    set_id(0, 8, 8, 1, 1, 0, 9);
    check("idle_nostall", stall, 0);
    check("idle_bubble", ex_bubble, 1);
    tick();
    check("idle_count", stall_count, 2);
    drain(3);

    // reset asserted during the stall cycle
    set_id(1, 1, 8, 0, 1, 1, 8);
    tick();
    set_id(1, 8, 2, 1, 1, 0, 9);
    check("rms_stall", stall, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rms_stall_clear", stall, 0);
    check("rms_advance", ex_bubble, 0);
    check("rms_count", stall_count, 0);
    check("rms_we", {mem_we_r, wb_we_r}, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    check("rms_lw_discarded", fwdA, 2'b00);
    check("rms_mem_empty", mem_we_r, 0);
    drain(3);

    // lw $8,0($8) held: stalls on alternate cycles until the counter saturates
    set_id(1, 8, 8, 0, 1, 1, 8);
    repeat (2 * (CMAX - 1)) tick();
    check("sat_below_max", stall_count, CMAX - 1);
    repeat (2) tick();
    check("sat_at_max", stall_count, CMAX);
    repeat (20) tick();
    check("sat_no_wrap", stall_count, CMAX);
    drain(3);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
